// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared pipeline constants, fetch FSM encoding and the IF/ID record.
package if_stage_pkg;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;
endpackage

// File: rtl/if_stage_pc_unit.sv
// if_stage_pc_unit: PC register, next-PC mux with redirect alignment, and memory range check.
module if_stage_pc_unit
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter int unsigned IMEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        in_range
);
    localparam logic [32:0] LIMIT = 33'(IMEM_DEPTH) << 2;
    logic [31:0] pc_n;
    always_comb pc_n = hold ? pc : redirect ? {redirect_pc[31:2], 2'b00} : pc + 32'd4;
    // 33-bit compare so a depth covering the full 4 GiB space never overflows
    assign in_range = {1'b0, pc} < LIMIT;
    always_ff @(posedge clk or posedge reset)
        if (reset) pc <= RESET_PC;
        else       pc <= pc_n;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with stall, redirect, halt, sticky fetch fault and fetch counter.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST   = DEF_NOP_INST,
    parameter int unsigned IMEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        stall_if,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_inst,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);
    fetch_state_t state, state_n;
    ifid_t        ifid, ifid_n;
    logic         fault_n, in_range, hold;
    logic [31:0]  count_n, pc;

    assign hold = (state == HALTED) || halt_req || (stall_if && !redirect_valid);

    if_stage_pc_unit #(.RESET_PC(RESET_PC), .IMEM_DEPTH(IMEM_DEPTH)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .redirect    (redirect_valid),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .in_range    (in_range)
    );

    always_comb begin
        state_n = state;
        ifid_n  = ifid;
        fault_n = fetch_fault;
        count_n = fetch_count;
        if (state == RUN) begin
            if (halt_req) begin
                state_n = HALTED;
                ifid_n  = '{pc: ifid.pc, inst: NOP_INST, valid: 1'b0};
            end else if (redirect_valid) begin
                ifid_n = '{pc: ifid.pc, inst: NOP_INST, valid: 1'b0};
            end else if (!stall_if) begin
                ifid_n  = in_range ? '{pc: pc, inst: imem_dout, valid: 1'b1}
                                   : '{pc: ifid.pc, inst: NOP_INST, valid: 1'b0};
                fault_n = fetch_fault || !in_range;
                count_n = in_range ? fetch_count + 32'd1 : fetch_count;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= RUN;
            ifid        <= '{pc: 32'd0, inst: NOP_INST, valid: 1'b0};
            fetch_fault <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            ifid        <= ifid_n;
            fetch_fault <= fault_n;
            fetch_count <= count_n;
        end

    assign imem_addr  = pc;
    assign ifid_pc    = ifid.pc;
    assign ifid_inst  = ifid.inst;
    assign ifid_valid = ifid.valid;
    assign halted     = (state == HALTED);
endmodule
